// File: rtl/stopwatch_multi_core_if.sv
// Pulse inputs and display/stash outputs of stopwatch_multi_core.
// lap_ch exists only when STOPWATCH_LAP_TAG_EN is defined.
interface stopwatch_multi_core_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 8,
    parameter int DEPTH = 5
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int LC_W  = $clog2(DEPTH + 1);

    logic             sel_toggle;
    logic             trig;
    logic             split;
    logic             clear;
    logic             sample;
    logic             next;
    logic [SEL_W-1:0] sel_ch;
    logic [CNT_W-1:0] time_out;
    logic [N_CH-1:0]  running;
    logic [CNT_W-1:0] lap_out;
    logic [LC_W-1:0]  lap_count;
    logic             lap_empty;
    logic             lap_full;
`ifdef STOPWATCH_LAP_TAG_EN
    logic [SEL_W-1:0] lap_ch;
`endif

    modport master (
        output sel_toggle, trig, split, clear, sample, next,
        input  sel_ch, time_out, running, lap_out, lap_count, lap_empty, lap_full
`ifdef STOPWATCH_LAP_TAG_EN
        , input lap_ch
`endif
    );

    modport slave (
        input  sel_toggle, trig, split, clear, sample, next,
        output sel_ch, time_out, running, lap_out, lap_count, lap_empty, lap_full
`ifdef STOPWATCH_LAP_TAG_EN
        , output lap_ch
`endif
    );
endinterface

// File: rtl/stopwatch_multi_core.sv
// Multi-channel stopwatch core: shared prescaler, per-channel FSMs, circular lap stash.
// Optional channel tag per stash entry under STOPWATCH_LAP_TAG_EN.
module stopwatch_multi_core #(
    parameter int N_CH      = 2,
    parameter int CLK_FREQ  = 100000000,
    parameter int TICK_HZ   = 10,
    parameter int CNT_W     = 8,
    parameter int MAX_COUNT = 99,
    parameter int DEPTH     = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    stopwatch_multi_core_if.slave bus
);
    localparam int PRESC = CLK_FREQ / TICK_HZ;
    localparam int PR_W  = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LC_W  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, RUN_FRZ, PAUSE} ch_state_t;

    logic [PR_W-1:0]  presc_q;
    logic             tick;
    logic [SEL_W-1:0] sel_q;
    ch_state_t        state_q [N_CH];
    ch_state_t        state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [CNT_W-1:0] frz_q   [N_CH];
    logic [CNT_W-1:0] frz_d   [N_CH];
    logic [N_CH-1:0]  run_vec;

    assign tick = (presc_q == PR_W'(PRESC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            sel_q   <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (bus.sel_toggle)
                sel_q <= (sel_q == SEL_W'(N_CH - 1)) ? '0 : sel_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                frz_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                frz_q[i]   <= frz_d[i];
            end
        end
    end

    // Tick increment comes first so clear / split-from-PAUSE can override the count.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            frz_d[i]   = frz_q[i];
            run_vec[i] = (state_q[i] == RUN) || (state_q[i] == RUN_FRZ);
            if (tick && run_vec[i])
                cnt_d[i] = (cnt_q[i] == CNT_W'(MAX_COUNT)) ? '0 : cnt_q[i] + 1'b1;
            if (sel_q == SEL_W'(i)) begin
                if (bus.clear) begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end else if (bus.trig) begin
                    case (state_q[i])
                        IDLE, PAUSE:  state_d[i] = RUN;
                        default:      state_d[i] = PAUSE;
                    endcase
                end else if (bus.split) begin
                    case (state_q[i])
                        RUN: begin
                            state_d[i] = RUN_FRZ;
                            frz_d[i]   = cnt_q[i];
                        end
                        RUN_FRZ: state_d[i] = RUN;
                        PAUSE: begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end
                        default: state_d[i] = state_q[i];
                    endcase
                end
            end
        end
    end

    logic [CNT_W-1:0] live_cnt;

    assign live_cnt     = cnt_q[sel_q];
    assign bus.sel_ch   = sel_q;
    assign bus.running  = run_vec;
    assign bus.time_out = (state_q[sel_q] == RUN_FRZ) ? frz_q[sel_q] : live_cnt;

    logic [CNT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LC_W-1:0]  lap_cnt;
    logic             empty;
    logic             full;
    logic [PTR_W-1:0] newest;
    logic [PTR_W-1:0] oldest;
    logic [PTR_W-1:0] rd_older;

    assign empty  = (lap_cnt == '0);
    assign full   = (lap_cnt == LC_W'(DEPTH));
    assign newest = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - 1'b1;
    // Until the first wrap entries occupy 0..lap_cnt-1; once full the oldest sits at wr_ptr.
    assign oldest = full ? wr_ptr : '0;

    always_comb begin
        rd_older = rd_ptr;
        if (rd_ptr == oldest)
            rd_older = newest;
        else if (rd_ptr == '0)
            rd_older = PTR_W'(DEPTH - 1);
        else
            rd_older = rd_ptr - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lap_cnt <= '0;
        end else if (bus.sample) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            rd_ptr <= wr_ptr;
            if (!full)
                lap_cnt <= lap_cnt + 1'b1;
        end else if (bus.next && !empty) begin
            rd_ptr <= rd_older;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.sample)
            mem[wr_ptr] <= live_cnt;
    end

    assign bus.lap_out   = empty ? '0 : mem[rd_ptr];
    assign bus.lap_count = lap_cnt;
    assign bus.lap_empty = empty;
    assign bus.lap_full  = full;

`ifdef STOPWATCH_LAP_TAG_EN
    logic [SEL_W-1:0] tag_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (bus.sample)
            tag_mem[wr_ptr] <= sel_q;
    end

    assign bus.lap_ch = empty ? '0 : tag_mem[rd_ptr];
`endif
endmodule

// File: tb/tb_stopwatch_multi_core.sv
// Bench for stopwatch_multi_core: directed sequences, a stash vector table and
// randomized pulses, all checked against a flag/queue-based reference model.
module tb_stopwatch_multi_core;
    localparam int MAXC = 99;
    localparam int DEP  = 5;
    localparam int TPER = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    stopwatch_multi_core_if #(.N_CH(2), .CNT_W(8), .DEPTH(DEP)) sw_if ();

    stopwatch_multi_core #(
        .N_CH(2), .CLK_FREQ(10), .TICK_HZ(1), .CNT_W(8), .MAX_COUNT(MAXC), .DEPTH(DEP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(sw_if.slave)
    );

    typedef struct packed {
        bit sel_toggle;
        bit trig;
        bit split;
        bit clear;
        bit sample;
        bit next;
    } pulse_t;

    typedef struct {
        int     edge_no;
        pulse_t p;
        int     exp_time;
        int     exp_lap;
        int     exp_cnt;
        bit     exp_full;
        bit     exp_empty;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: flags per channel, stash as a queue (oldest first).
    int m_edges;
    int m_sel;
    bit m_run [2];
    bit m_frz [2];
    bit m_pause [2];
    int m_cnt [2];
    int m_fv [2];
    int laps [$];
    int m_rd;

    task automatic model_reset();
        m_edges = 0;
        m_sel = 0;
        m_rd = 0;
        laps.delete();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_frz[i] = 0; m_pause[i] = 0; m_cnt[i] = 0; m_fv[i] = 0;
        end
    endtask

    task automatic model_step(input pulse_t p);
        bit tick;
        int s, old;
        tick = (m_edges % TPER) == TPER - 1;
        m_edges++;
        s = m_sel;
        old = m_cnt[s];
        for (int i = 0; i < 2; i++)
            if (tick && m_run[i]) m_cnt[i] = (m_cnt[i] == MAXC) ? 0 : m_cnt[i] + 1;
        if (p.clear) begin
            m_run[s] = 0; m_frz[s] = 0; m_pause[s] = 0; m_cnt[s] = 0;
        end else if (p.trig) begin
            if (m_run[s]) begin
                m_run[s] = 0; m_frz[s] = 0; m_pause[s] = 1;
            end else begin
                m_run[s] = 1; m_pause[s] = 0;
            end
        end else if (p.split) begin
            if (m_run[s] && !m_frz[s]) begin
                m_frz[s] = 1; m_fv[s] = old;
            end else if (m_run[s]) begin
                m_frz[s] = 0;
            end else if (m_pause[s]) begin
                m_pause[s] = 0; m_cnt[s] = 0;
            end
        end
        if (p.sample) begin
            laps.push_back(old);
            if (laps.size() > DEP) void'(laps.pop_front());
            m_rd = laps.size() - 1;
        end else if (p.next && laps.size() > 0) begin
            m_rd = (m_rd == 0) ? laps.size() - 1 : m_rd - 1;
        end
        if (p.sel_toggle) m_sel = (m_sel + 1) % 2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        int et;
        et = m_frz[m_sel] ? m_fv[m_sel] : m_cnt[m_sel];
        chk("model_time_out", int'(sw_if.time_out), et);
        chk("model_running", int'(sw_if.running), {30'd0, m_run[1], m_run[0]});
        chk("model_sel_ch", int'(sw_if.sel_ch), m_sel);
        chk("model_lap_out", int'(sw_if.lap_out), (laps.size() > 0) ? laps[m_rd] : 0);
        chk("model_lap_count", int'(sw_if.lap_count), laps.size());
        chk("model_lap_empty", int'(sw_if.lap_empty), int'(laps.size() == 0));
        chk("model_lap_full", int'(sw_if.lap_full), int'(laps.size() == DEP));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_time_out"}, int'(sw_if.time_out), 0);
        chk({tag, "_running"}, int'(sw_if.running), 0);
        chk({tag, "_sel_ch"}, int'(sw_if.sel_ch), 0);
        chk({tag, "_lap_out"}, int'(sw_if.lap_out), 0);
        chk({tag, "_lap_count"}, int'(sw_if.lap_count), 0);
        chk({tag, "_lap_empty"}, int'(sw_if.lap_empty), 1);
        chk({tag, "_lap_full"}, int'(sw_if.lap_full), 0);
    endtask

    task automatic drive(input pulse_t p);
        sw_if.sel_toggle = p.sel_toggle;
        sw_if.trig       = p.trig;
        sw_if.split      = p.split;
        sw_if.clear      = p.clear;
        sw_if.sample     = p.sample;
        sw_if.next       = p.next;
    endtask

    // One clock: inputs applied before the edge, outputs sampled 1 time unit after.
    task automatic cyc(input pulse_t p);
        drive(p);
        @(posedge clk);
        model_step(p);
        #1;
        drive('0);
        check_model();
    endtask

    task automatic idle_to(input int e);
        while (m_edges <= e) cyc('0);
    endtask

    task automatic act_at(input int e, input pulse_t p);
        idle_to(e - 1);
        cyc(p);
    endtask

    function automatic pulse_t mk(input bit st, input bit tr, input bit sp,
                                  input bit cl, input bit sa, input bit nx);
        pulse_t p;
        p = '{st, tr, sp, cl, sa, nx};
        return p;
    endfunction

    vec_t tbl [14];

    initial begin
        drive('0);
        model_reset();

        tbl[0]  = '{1100, mk(0,1,0,0,0,0),  0,  0, 0, 0, 1};
        tbl[1]  = '{1150, mk(0,0,0,0,0,1),  5,  0, 0, 0, 1};
        tbl[2]  = '{1200, mk(0,0,0,0,1,0), 10, 10, 1, 0, 0};
        tbl[3]  = '{1300, mk(0,0,0,0,1,0), 20, 20, 2, 0, 0};
        tbl[4]  = '{1400, mk(0,0,0,0,1,0), 30, 30, 3, 0, 0};
        tbl[5]  = '{1500, mk(0,0,0,0,1,0), 40, 40, 4, 0, 0};
        tbl[6]  = '{1600, mk(0,0,0,0,1,0), 50, 50, 5, 1, 0};
        tbl[7]  = '{1700, mk(0,0,0,0,1,0), 60, 60, 5, 1, 0};
        tbl[8]  = '{1701, mk(0,0,0,0,0,1), 60, 50, 5, 1, 0};
        tbl[9]  = '{1702, mk(0,0,0,0,0,1), 60, 40, 5, 1, 0};
        tbl[10] = '{1703, mk(0,0,0,0,0,1), 60, 30, 5, 1, 0};
        tbl[11] = '{1704, mk(0,0,0,0,0,1), 60, 20, 5, 1, 0};
        tbl[12] = '{1705, mk(0,0,0,0,0,1), 60, 60, 5, 1, 0};
        tbl[13] = '{1712, mk(0,0,0,0,1,1), 61, 61, 5, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Start, first tick, count after 50 cycles
        act_at(3, mk(0,1,0,0,0,0));
        chk("trig_running", int'(sw_if.running), 1);
        idle_to(9);
        chk("first_tick", int'(sw_if.time_out), 1);
        idle_to(49);
        chk("count_50cyc", int'(sw_if.time_out), 5);

        // Split freeze / release, pause then split to IDLE
        act_at(50, mk(0,0,1,0,0,0));
        idle_to(70);
        chk("frozen_display", int'(sw_if.time_out), 5);
        act_at(71, mk(0,0,1,0,0,0));
        chk("split_release", int'(sw_if.time_out), 7);
        act_at(72, mk(0,1,0,0,0,0));
        act_at(73, mk(0,0,1,0,0,0));
        chk("pause_split_idle", int'(sw_if.time_out), 0);
        chk("pause_split_run", int'(sw_if.running), 0);

        // Selection: trig with sel_toggle acts on the old channel
        act_at(74, mk(1,0,0,0,0,0));
        act_at(75, mk(0,1,0,0,0,0));
        chk("ch1_run", int'(sw_if.running), 2);
        act_at(76, mk(1,1,0,0,0,0));
        chk("trig_old_sel_run", int'(sw_if.running), 0);
        chk("trig_old_sel_sel", int'(sw_if.sel_ch), 0);
        act_at(77, mk(0,1,0,0,0,0));
        act_at(78, mk(1,0,0,0,0,0));
        act_at(79, mk(0,1,0,0,0,0));
        chk("both_running", int'(sw_if.running), 3);
        chk("sel_is_1", int'(sw_if.sel_ch), 1);
        idle_to(89);
        chk("ch1_display", int'(sw_if.time_out), 1);
        act_at(90, mk(1,0,0,0,0,0));
        chk("ch0_display", int'(sw_if.time_out), 2);

        // Wrap at MAX_COUNT, then clear mid-run
        act_at(91, mk(0,0,0,1,0,0));
        act_at(92, mk(1,0,0,0,0,0));
        act_at(93, mk(0,0,0,1,0,0));
        act_at(94, mk(1,0,0,0,0,0));
        chk("all_cleared", int'(sw_if.running), 0);
        act_at(95, mk(0,1,0,0,0,0));
        idle_to(1079);
        chk("at_max", int'(sw_if.time_out), 99);
        idle_to(1089);
        chk("wrap_zero", int'(sw_if.time_out), 0);
        chk("wrap_running", int'(sw_if.running), 1);
        act_at(1095, mk(0,0,0,1,0,0));
        chk("clear_time", int'(sw_if.time_out), 0);
        chk("clear_running", int'(sw_if.running), 0);

        // Lap stash vectors
        for (int k = 0; k < 14; k++) begin
            act_at(tbl[k].edge_no, tbl[k].p);
            chk($sformatf("vec%0d_time", k), int'(sw_if.time_out), tbl[k].exp_time);
            chk($sformatf("vec%0d_lap_out", k), int'(sw_if.lap_out), tbl[k].exp_lap);
            chk($sformatf("vec%0d_lap_count", k), int'(sw_if.lap_count), tbl[k].exp_cnt);
            chk($sformatf("vec%0d_lap_full", k), int'(sw_if.lap_full), int'(tbl[k].exp_full));
            chk($sformatf("vec%0d_lap_empty", k), int'(sw_if.lap_empty), int'(tbl[k].exp_empty));
        end

        // Asynchronous reset between clock edges
        idle_to(1720);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        check_model();

        // Randomized pulses against the model
        for (int n = 0; n < 3000; n++) begin
            pulse_t p;
            p.sel_toggle = ($urandom_range(15) == 0);
            p.trig       = ($urandom_range(11) == 0);
            p.split      = ($urandom_range(11) == 0);
            p.clear      = ($urandom_range(63) == 0);
            p.sample     = ($urandom_range(15) == 0);
            p.next       = ($urandom_range(7) == 0);
            cyc(p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
